spi_frame_timer: RTL and testbench
==================================

// Module: spi_frame_timer
// PURPOSE
//  Generates SPI serial clock `sclk` and frame bit index `n` from the system clock for the accelerometer SPI master.
//  Sits directly upstream of the SPI master, which decodes `n` (1..FRAME_LEN) on sclk edges to sequence MOSI/MISO/cs.
//  Adds frame gaps, start/done strobes, a run enable and a frame counter so reads repeat at a controlled rate.
// PARAMETERS
//  CLK_DIV    50  clk cycles per sclk half-period (100 MHz clk -> 1 MHz sclk); legal >= 2
//  FRAME_LEN  26  last value of n in a frame; n counts 1..FRAME_LEN
//  GAP_LEN    4   full sclk periods with n==0 between frames; legal >= 1
//  N_W        6   width of n; 2**N_W > FRAME_LEN
// PORTS
//  clk          in   1    system clock
//  rst          in   1    synchronous, active-high reset
//  en           in   1    run request; level-sensitive
//  sclk         out  1    SPI clock, idle high (CPOL=1)
//  n            out  N_W  frame bit index; 0 outside frames
//  busy         out  1    high in RUN and GAP
//  frame_start  out  1    1-clk pulse when n goes 0->1
//  frame_done   out  1    1-clk pulse when n leaves FRAME_LEN
//  frame_cnt    out  16   completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst high at clk edge): sclk=1, n=0, busy=0, pulses=0, frame_cnt=0, div_cnt=0, state=IDLE. Takes effect mid-frame too; no frame completion.
//  Divider: div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1 wraps to 0 and sclk toggles ("tick"). Rise tick = sclk 0->1, fall tick = 1->0.
//  n, state, pulses change only on the clk edge of a rise tick, so n is stable for the full sclk low-to-high span around each falling edge.
//  FSM (evaluated on rise ticks):
//   IDLE: n=0. en=1 -> RUN, n=1, frame_start pulses.
//   RUN : n<FRAME_LEN -> n+1. n==FRAME_LEN -> GAP, n=0, frame_done pulses, frame_cnt+1, gap_cnt=1.
//   GAP : n=0. gap_cnt<GAP_LEN -> gap_cnt+1. gap_cnt==GAP_LEN -> en ? (RUN, n=1, frame_start) : IDLE.
//  en deasserted mid-frame: frame runs to FRAME_LEN, then GAP, then IDLE. en is never sampled in RUN.
//  Frame length in sclk periods: FRAME_LEN; frame-to-frame period: FRAME_LEN+GAP_LEN.
//  IDLE->RUN latency: frame_start at first rise tick with en=1 (<= 2*CLK_DIV clks after en rises).
//  frame_done and frame_start never coincide (GAP_LEN >= 1).
// CONFIGURATION
//  SCLK_GATE_EN defined: sclk held at 1 while in IDLE or GAP; divider keeps running so tick phase is preserved; first falling edge of a frame occurs CLK_DIV clks after the rise tick that sets n=1.
//  SCLK_GATE_EN undefined (default): sclk free-runs in all states after reset, as the SPI master's power-up config sequence counts raw sclk edges.
// STRUCTURE
//  Package spi_acc_pkg: state enum {IDLE,RUN,GAP}, FRAME_LEN_DEF=26, N_W_DEF=6 shared with the SPI master.
//  One sub-module: spi_clk_div (div_cnt, sclk toggle, rise_tick/fall_tick strobes). FSM, n and counters stay in top.
// TESTING
//  CLK_DIV=4,en=0 after rst -> n=0, busy=0; sclk toggles every 4 clks (gated: sclk stays 1).
//  en=1 held -> frame_start; n steps 1..26, one step per 8 clks; frame_done; 4 periods n=0; next frame_start 30 sclk periods after first.
//  en dropped when n==10 -> n reaches 26, frame_done, frame_cnt=1, GAP 4 periods, IDLE, busy=0.
//  rst pulsed when n==15 -> next clk: n=0, sclk=1, frame_cnt=0, no frame_done.
//  Preload frame_cnt near wrap (force 0xFFFF) and finish frame -> frame_cnt=0x0000.
//  Check n constant across every sclk falling edge; assertion n<=26 always.

Source files
------------

// File: rtl/spi_acc_pkg.sv
// Shared definitions for the accelerometer SPI path: frame FSM states and
// default frame geometry used by both the frame timer and the SPI master.
package spi_acc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;
  localparam int FRAME_LEN_DEF = 26;
  localparam int N_W_DEF       = 6;
endpackage

// File: rtl/spi_clk_div.sv
// Free-running sclk divider: toggles sclk every CLK_DIV clocks and flags the
// clock edge on which sclk rises (rise_tick) or falls (fall_tick).
module spi_clk_div #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  always_comb begin
    tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    sclk_d    = tick ? ~sclk_q : sclk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  // Strobes mark the clk edge that performs the toggle, not the cycle after.
  assign rise_tick = tick & ~sclk_q;
  assign fall_tick = tick &  sclk_q;
  assign sclk      = sclk_q;
endmodule

// File: rtl/spi_frame_timer.sv
// SPI frame sequencer: produces sclk and bit index n (1..FRAME_LEN) with gaps,
// start/done strobes and a frame counter. Define SCLK_GATE_EN to park sclk high outside frames.
module spi_frame_timer
  import spi_acc_pkg::*;
#(
  parameter int CLK_DIV   = 50,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int GAP_LEN   = 4,
  parameter int N_W       = N_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic           sclk,
  output logic [N_W-1:0] n,
  output logic           busy,
  output logic           frame_start,
  output logic           frame_done,
  output logic [15:0]    frame_cnt
);
  localparam int GAP_W = $clog2(GAP_LEN + 1);

  logic sclk_int, rise_tick, unused_fall_tick;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk_int),
    .rise_tick (rise_tick),
    .fall_tick (unused_fall_tick)
  );

  state_e           state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  // Everything advances only on rise ticks so n is stable across each sclk fall.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    gap_cnt_d     = gap_cnt_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (rise_tick) begin
      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_d       = RUN;
            n_d           = N_W'(1);
            frame_start_d = 1'b1;
          end
        end
        RUN: begin
          if (n_q == N_W'(FRAME_LEN)) begin
            state_d      = GAP;
            n_d          = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            gap_cnt_d    = GAP_W'(1);
          end else begin
            n_d = n_q + N_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_LEN)) begin
            if (en) begin
              state_d       = RUN;
              n_d           = N_W'(1);
              frame_start_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      n_q           <= '0;
      gap_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef SCLK_GATE_EN
  // Divider keeps running underneath so the first in-frame fall keeps its phase.
  assign sclk = (state_q == RUN) ? sclk_int : 1'b1;
`else
  assign sclk = sclk_int;
`endif

  assign n           = n_q;
  assign busy        = (state_q != IDLE);
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_spi_frame_timer.sv
// Randomised bench for spi_frame_timer against a frame-position reference model.
module tb_spi_frame_timer;
  localparam int CLK_DIV   = 4;
  localparam int FRAME_LEN = 26;
  localparam int GAP_LEN   = 4;
  localparam int N_W       = 6;
  localparam int PERIOD    = FRAME_LEN + GAP_LEN;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic           sclk;
  logic [N_W-1:0] n;
  logic           busy, frame_start, frame_done;
  logic [15:0]    frame_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed clocks since reset and position within a frame period.
  int          cyc    = 0;
  int          tclk   = 0;
  bit          m_run  = 0;
  int          m_pos  = 0;
  bit          m_start = 0;
  bit          m_done  = 0;
  logic [15:0] m_cnt  = '0;

  spi_frame_timer #(.CLK_DIV(CLK_DIV), .FRAME_LEN(FRAME_LEN), .GAP_LEN(GAP_LEN), .N_W(N_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sclk(sclk), .n(n), .busy(busy),
    .frame_start(frame_start), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    assert (n <= N_W'(FRAME_LEN)) else $error("FAIL n_range n=%0d", n);

  // Advance one clk edge and update the model with the inputs seen at that edge.
  task automatic step();
    bit en_s  = en;
    bit rst_s = rst;
    @(posedge clk);
    tclk++;
    m_start = 0;
    m_done  = 0;
    if (rst_s) begin
      cyc = 0; m_run = 0; m_pos = 0; m_cnt = '0;
    end else begin
      cyc++;
      if (cyc % CLK_DIV == 0 && (cyc / CLK_DIV) % 2 == 0) begin
        if (!m_run) begin
          if (en_s) begin m_run = 1; m_pos = 0; m_start = 1; end
        end else begin
          m_pos++;
          if (m_pos == FRAME_LEN) begin
            m_done = 1; m_cnt = m_cnt + 16'd1;
          end else if (m_pos == PERIOD) begin
            if (en_s) begin m_pos = 0; m_start = 1; end
            else m_run = 0;
          end
        end
      end
    end
    #1;
  endtask

  function automatic logic [25:0] exp_vec();
    bit         s_int    = ((cyc / CLK_DIV) % 2) == 0;
    bit         in_frame = m_run && (m_pos < FRAME_LEN);
    logic [5:0] ne       = in_frame ? 6'(m_pos + 1) : 6'd0;
    bit         s        = s_int;
`ifdef SCLK_GATE_EN
    s = in_frame ? s_int : 1'b1;
`endif
    return {s, ne, m_run, m_start, m_done, m_cnt};
  endfunction

  function automatic logic [25:0] obs_vec();
    return {sclk, n, busy, frame_start, frame_done, frame_cnt};
  endfunction

  task automatic test_reset();
    rst = 1; en = 0;
    step(); step();
    checks++;
    if ({sclk, n, busy, frame_start, frame_done, frame_cnt} !== {1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state got sclk=%b n=%0d busy=%b fs=%b fd=%b cnt=%0d want 1/0/0/0/0/0",
               sclk, n, busy, frame_start, frame_done, frame_cnt);
    end
    rst = 0;
  endtask

  task automatic test_idle_sclk();
    int toggles = 0;
    logic prev = sclk;
    for (int i = 0; i < 8 * CLK_DIV; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL idle_cycle%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (sclk !== prev) toggles++;
      prev = sclk;
    end
    checks++;
`ifdef SCLK_GATE_EN
    if (toggles !== 0) begin errors++; $display("FAIL idle_toggles got %0d want 0", toggles); end
`else
    if (toggles !== 8) begin errors++; $display("FAIL idle_toggles got %0d want 8", toggles); end
`endif
  endtask

  task automatic test_frames();
    int starts[$];
    int dones = 0;
    int en_t;
    en = 1;
    en_t = tclk;
    for (int i = 0; i < 2 * PERIOD * 2 * CLK_DIV + 16; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL frames_cycle%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (frame_start) starts.push_back(tclk);
      if (frame_done) dones++;
    end
    checks++;
    if (starts.size() < 2) begin
      errors++; $display("FAIL frames_starts got %0d want >=2", starts.size());
    end else begin
      checks += 2;
      if (starts[0] - en_t > 2 * CLK_DIV) begin
        errors++; $display("FAIL start_latency got %0d want <=%0d", starts[0] - en_t, 2 * CLK_DIV);
      end
      if (starts[1] - starts[0] != PERIOD * 2 * CLK_DIV) begin
        errors++; $display("FAIL start_period got %0d want %0d", starts[1] - starts[0], PERIOD * 2 * CLK_DIV);
      end
    end
    checks++;
    if (dones < 2) begin errors++; $display("FAIL frames_dones got %0d want >=2", dones); end
  endtask

  task automatic test_en_drop();
    int guard = 0;
    while (n !== 6'd10 && guard < 1000) begin step(); guard++; end
    checks++;
    if (guard >= 1000) begin errors++; $display("FAIL en_drop_wait got timeout want n=10"); end
    en = 0;
    guard = 0;
    do begin
      step(); guard++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL en_drop_cycle%0d got %h want %h", guard, obs_vec(), exp_vec());
      end
    end while (busy && guard < 1000);
    checks++;
    if (busy !== 1'b0 || n !== '0) begin
      errors++; $display("FAIL en_drop_idle got busy=%b n=%0d want 0/0", busy, n);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    rst = 1; step(); rst = 0;
    en = 1;
    while (n !== 6'd15 && guard < 1000) begin step(); guard++; end
    checks++;
    if (guard >= 1000) begin errors++; $display("FAIL rst_mid_wait got timeout want n=15"); end
    rst = 1;
    step();
    checks++;
    if ({n, sclk, frame_cnt, frame_done, busy} !== {6'd0, 1'b1, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid got n=%0d sclk=%b cnt=%0d fd=%b busy=%b want 0/1/0/0/0", n, sclk, frame_cnt, frame_done, busy);
    end
    rst = 0; en = 0;
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_mid_after%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    bit seen = 0;
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    en = 1;
    while (!seen && guard < 1000) begin
      step(); guard++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap_cycle%0d got %h want %h", guard, obs_vec(), exp_vec());
      end
      if (frame_done) seen = 1;
    end
    checks++;
    if (!seen || frame_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap got done=%b cnt=%h want 1/0000", seen, frame_cnt);
    end
    en = 0;
  endtask

  task automatic test_random();
    logic           prev_s = sclk;
    logic [N_W-1:0] prev_n = n;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(63) == 0) en = ~en;
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (prev_s === 1'b1 && sclk === 1'b0) begin
        checks++;
        if (n !== prev_n) begin
          errors++; $display("FAIL n_stable_fall got %0d want %0d", n, prev_n);
        end
      end
      prev_s = sclk;
      prev_n = n;
    end
    en = 0;
  endtask

  initial begin
    test_reset();
    test_idle_sclk();
    test_frames();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
